// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential RV32M multiply/divide unit:
// funct3 encodings, FSM states, iteration count and operand signedness helpers.
package muldiv_pkg;

  localparam int ITER_DEFAULT = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic op_a_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative RV32M unit: one shift-add or restoring shift-subtract step per cycle
// on operand magnitudes, with sign correction applied in DONE.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WORD_BITWIDTH = 32,
  parameter int ITER          = ITER_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [2:0]               funct3,
  input  logic [WORD_BITWIDTH-1:0] op_a,
  input  logic [WORD_BITWIDTH-1:0] op_b,
  input  logic                     flush,
  output logic                     stall_req,
  output logic                     busy,
  output logic                     done,
  output logic [WORD_BITWIDTH-1:0] result
);

  localparam int W  = WORD_BITWIDTH;
  localparam int CW = $clog2(ITER + 1);
  localparam logic [W-1:0] W_MIN = {1'b1, {(W-1){1'b0}}};

  state_t         r_state, w_state_next;
  logic [2:0]     r_funct3;
  logic           r_neg_a, r_neg_b;
  logic [W-1:0]   r_mag_a, r_mag_b;
  logic [2*W-1:0] r_acc;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_result;

  logic           w_accept, w_neg_a, w_neg_b, w_div0, w_ovf;
  logic [W-1:0]   w_mag_a, w_mag_b;
  logic [W:0]     w_mul_hi, w_div_shift, w_div_diff;
  logic           w_div_ge;
  logic [2*W-1:0] w_step, w_prod;
  logic [W-1:0]   w_quot, w_rem, w_final;

  assign w_accept = (r_state == ST_IDLE) && start && !flush;
  assign w_neg_a  = op_a_signed(funct3) && op_a[W-1];
  assign w_neg_b  = op_b_signed(funct3) && op_b[W-1];
  assign w_mag_a  = w_neg_a ? -op_a : op_a;
  assign w_mag_b  = w_neg_b ? -op_b : op_b;
  assign w_div0   = funct3[2] && (op_b == '0);
  assign w_ovf    = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                    (op_a == W_MIN) && (op_b == {W{1'b1}});

  // Multiply: {hi, lo} with multiplier in lo, consumed LSB first.
  // Divide: hi holds the partial remainder, lo shifts dividend out / quotient in.
  assign w_mul_hi    = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_mag_a} : '0);
  assign w_div_shift = {r_acc[2*W-1:W], r_acc[W-1]};
  assign w_div_ge    = w_div_shift >= {1'b0, r_mag_b};
  assign w_div_diff  = w_div_shift - {1'b0, r_mag_b};

  always_comb begin
    w_step = {r_acc[2*W-2:0], 1'b0};
    if (!r_funct3[2]) begin
      w_step = {w_mul_hi, r_acc[W-1:1]};
    end else if (w_div_ge) begin
      w_step = {w_div_diff[W-1:0], r_acc[W-2:0], 1'b1};
    end
  end

  assign w_prod = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;
  assign w_quot = (r_neg_a ^ r_neg_b) ? -r_acc[W-1:0] : r_acc[W-1:0];
  assign w_rem  = r_neg_a ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

  always_comb begin
    case (r_funct3)
      F3_MUL:          w_final = w_prod[W-1:0];
      F3_DIV, F3_DIVU: w_final = w_quot;
      F3_REM, F3_REMU: w_final = w_rem;
      default:         w_final = w_prod[2*W-1:W];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    stall_req    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    result       = r_result;
    case (r_state)
      ST_IDLE: begin
        stall_req = w_accept && rst_n;
        if (w_accept) w_state_next = (w_div0 || w_ovf) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        stall_req = 1'b1;
        busy      = 1'b1;
        if (flush)                           w_state_next = ST_IDLE;
        else if (r_cnt == CW'(ITER - 1))     w_state_next = ST_DONE;
      end
      ST_DONE: begin
        busy         = 1'b1;
        done         = !flush;
        w_state_next = ST_IDLE;
        if (!flush) result = w_final;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_funct3 <= F3_MUL;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_funct3 <= funct3;
      r_cnt    <= '0;
      r_mag_a  <= w_mag_a;
      r_mag_b  <= w_mag_b;
      // Special divides preload the final quotient/remainder with no sign fix-up.
      if (w_div0) begin
        r_neg_a <= 1'b0;
        r_neg_b <= 1'b0;
        r_acc   <= {op_a, {W{1'b1}}};
      end else if (w_ovf) begin
        r_neg_a <= 1'b0;
        r_neg_b <= 1'b0;
        r_acc   <= {{W{1'b0}}, W_MIN};
      end else begin
        r_neg_a <= w_neg_a;
        r_neg_b <= w_neg_b;
        r_acc   <= {{W{1'b0}}, funct3[2] ? w_mag_a : w_mag_b};
      end
    end else if (r_state == ST_RUN) begin
      r_acc <= w_step;
      r_cnt <= r_cnt + CW'(1);
    end else if (r_state == ST_DONE && !flush) begin
      r_result <= w_final;
    end
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter WORD_BITWIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter ITER, default 32, number of RUN iterations (equal to WORD_BITWIDTH).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  request to begin an RV32M operation; sampled only in IDLE.
REQ-006 SHALL have port funct3  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port op_a  input  WORD_BITWIDTH  rs1 value, after forwarding.
REQ-008 SHALL have port op_b  input  WORD_BITWIDTH  rs2 value, after forwarding.
REQ-009 SHALL have port flush  input  1  kill the in-flight operation (branch/jump redirect).
REQ-010 SHALL have port stall_req  output  1  hold IF/ID/EX pipeline registers.
REQ-011 SHALL have port busy  output  1  high in RUN or DONE.
REQ-012 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-013 SHALL have port result  output  WORD_BITWIDTH  final value, held until the next accepted start.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 IDLE & start & !flush SHALL latch funct3, op_a and op_b, clear the iteration counter, and go to RUN next edge.
REQ-016 Operands SHALL be latched as magnitudes plus sign flags; signedness per funct3: MULH/DIV/REM both signed, MULHSU op_a only, others unsigned.
REQ-017 RUN SHALL perform one shift-add (multiply, 64-bit accumulator) or one restoring shift-subtract (divide) step per cycle, incrementing the counter.
REQ-018 RUN SHALL go to DONE on the edge completing iteration ITER.
REQ-019 Latency: acceptance edge at cycle 0 -> done high in cycle ITER+1 (33 at default).
REQ-020 DONE SHALL drive done=1 for exactly one cycle, apply sign correction, load result, then go to IDLE.
REQ-021 result SHALL be selected as: MUL = low word; MULH/MULHSU/MULHU = high word; DIV/DIVU = quotient; REM/REMU = remainder.
REQ-022 Remainder sign SHALL follow the dividend; quotient SHALL be negated when operand signs differ.
REQ-023 Divide by zero SHALL bypass RUN and go IDLE->DONE with latency 1; quotient = all ones, remainder = op_a.
REQ-024 Signed overflow (DIV/REM, op_a=0x80000000, op_b=0xFFFFFFFF) SHALL bypass RUN with latency 1; quotient = 0x80000000, remainder = 0.
REQ-025 stall_req SHALL be asserted combinationally for (IDLE & start & !flush) or RUN, and deasserted in DONE so the pipeline captures result.
REQ-026 start in RUN or DONE SHALL be ignored.
REQ-027 flush in RUN or DONE SHALL return the FSM to IDLE next edge, suppress done, and leave result unchanged.
REQ-028 flush in IDLE SHALL override start.

Reset
REQ-029 rst_n low SHALL asynchronously force state=IDLE, counter=0, and stall_req=0, busy=0, done=0, result=0.
REQ-030 Reset asserted mid-RUN SHALL abandon the operation with no done pulse.
REQ-031 Reset release SHALL take effect on the first subsequent clk edge.

Structure
REQ-032 The funct3 encodings, FSM state encoding and ITER default SHALL live in the shared package muldiv_pkg.
REQ-033 The block SHALL be a single module with no sub-modules; the existing ALU SHALL NOT be reused for iterations.

Verification
REQ-034 MUL 7 x -3: start at cycle 0 -> done at cycle 33, result 0xFFFFFFEB; stall_req high cycles 0-32, low at 33.
REQ-035 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE; MULH of the same operands -> result 0x00000000.
REQ-036 DIV -7/2 -> result 0xFFFFFFFD; REM -7/2 -> result 0xFFFFFFFF; each after 33 cycles.
REQ-037 DIVU 5/0 -> done at cycle 1, result 0xFFFFFFFF; DIV 0x80000000/-1 -> done at cycle 1, result 0x80000000.
REQ-038 flush at cycle 10 of a DIVU -> IDLE at cycle 11, no done pulse, result unchanged; a new start at cycle 12 is accepted.
REQ-039 rst_n low at cycle 15 of MUL -> all outputs 0 immediately; start held through DONE -> second operation begins only after return to IDLE.
